seg_frame_reader: RTL and testbench
===================================

Name: seg_frame_reader

Overview:
- Reverse of the team's BCD-to-7-segment decoder: samples a multiplexed 7-segment bus (one digit selected per scan slot) and reconstructs the displayed digit values.
- Filters scan glitches by requiring each digit's pattern to repeat STABLE times before accepting it.
- Packs a complete multi-digit frame and hands it to the consumer over a valid/ready handshake.
- Sits between the display driver outputs and self-check/readback logic of the nap timer.

Parameters:
- DIGITS, 4, number of multiplexed digits; 1..8.
- STABLE, 3, consecutive identical samples of a digit required for acceptance; 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- seg_in  in  7  segment pattern, active-high; bit0=a, bit1=b, bit2=c, bit3=d, bit4=e, bit5=f, bit6=g.
- dig_sel  in  DIGITS  one-hot digit select; bit i is digit i, and digit 0 is the least significant nibble.
- sample_en  in  1  seg_in/dig_sel are valid this cycle.
- frame_ready  in  1  consumer accepts the frame.
- frame_valid  out  1  frame_bcd/frame_err hold a frame.
- frame_bcd  out  4*DIGITS  packed digit codes.
- frame_err  out  1  at least one digit in the frame is invalid (code F).
- overrun  out  1  one-cycle pulse when a completed frame is dropped.
- sel_err  out  1  one-cycle pulse when a sample is ignored for a bad dig_sel.

Behaviour:
- Reset (async, immediate): frame_valid=0, frame_bcd=0, frame_err=0, overrun=0, sel_err=0, all candidates=0, counts=0, accepted mask=0.
- Decode (combinational, exact match only):
  - Digits: 0x3F→0, 0x06→1, 0x5B→2, 0x4F→3, 0x66→4, 0x6D→5, 0x7D→6, 0x07→7, 0x7F→8, 0x6F→9.
  - 0x00→A (blank).
  - Any other pattern→F (invalid).
- Sample handling: on a clk edge with sample_en=1:
  - dig_sel not exactly one-hot (zero or multiple bits): sample ignored, no state change, sel_err=1 next cycle.
  - Otherwise, for the selected digit i:
    - If code==cand[i], cnt[i] increments, saturating at STABLE.
    - Else cand[i]=code and cnt[i]=1.
    - When cnt[i] reaches STABLE on this update, mask[i] is set and val[i]=cand[i].
    - Later matching samples leave mask[i] set.
    - A later differing sample restarts the filter but does not clear mask[i] or val[i].
  - With STABLE=1, every one-hot sample is accepted immediately.
- Frame completion:
  - When mask is all ones after an update, a commit request is raised on the following edge (edge N+1 of the completing sample edge N).
  - At the commit edge, mask, cnt and cand clear for all digits.
  - The first sample of each digit therefore starts afresh for the next frame.
  - Samples arriving on the commit edge are applied after the clear.
- Output FSM states:
  - EMPTY (frame_valid=0).
  - FULL (frame_valid=1, frame_bcd/frame_err stable).
- Transitions:
  - EMPTY + commit → FULL: load frame_bcd = {val[DIGITS-1],…,val[0]}; frame_err = any val==F. frame_valid is first high in the cycle after the commit edge, i.e. 2 edges after the completing sample.
  - FULL + frame_ready, no commit → EMPTY.
  - FULL + frame_ready + commit on the same edge → stays FULL with the new frame loaded; no overrun.
  - FULL + commit, frame_ready=0 → frame dropped; outputs unchanged; overrun=1 for one cycle.
  - frame_ready while EMPTY → ignored.
- frame_valid never deasserts without a handshake, except on reset.
- Reset mid-frame discards partial masks and any held frame.

Test Plan:
- DIGITS=4, STABLE=3; present digit3..0 patterns 0x06,0x5B,0x4F,0x66, each 3 times in round-robin, frame_ready=1 → frame_valid high for exactly 1 cycle, 2 edges after the last sample; frame_bcd=0x1234; frame_err=0.
- Digit 0 gets 0x6D,0x6D,0x7D,0x7D,0x7D while the others are stable at 0x3F → frame_bcd=0x0006. Digit 0 is never accepted as 5.
- Digit 2 shows 0x49 three times, the others valid; then digit 1 shows 0x00 three times → frame_bcd has nibble2=F and nibble1=A; frame_err=1.
- Hold frame_ready=0 after the first frame 0x1234, then complete frame 0x5678 → overrun pulses once and frame_bcd stays 0x1234. Raise frame_ready → frame_valid drops. A third frame is then delivered normally.
- sample_en with dig_sel=4'b0000 and then 4'b0110 → sel_err pulses twice; counts and masks unchanged; frame content unaffected.
- Assert rst asynchronously (mid-cycle) with 3 of 4 digits accepted and frame_valid=1 → all outputs 0 immediately. After release, the full 12-sample sequence is needed to produce the next frame.

Source files
------------

// File: rtl/seg_frame_reader.sv
`default_nettype none
// ============================================================================
// Module   : seg_frame_reader
// Purpose  : Samples a multiplexed 7-segment bus, debounces each digit and
//            hands complete multi-digit BCD frames over a valid/ready port.
// Revision : 1.0
// ============================================================================
module seg_frame_reader #(
    parameter int DIGITS = 4,
    parameter int STABLE = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [6:0]            seg_in,
    input  logic [DIGITS-1:0]     dig_sel,
    input  logic                  sample_en,
    input  logic                  frame_ready,
    output logic                  frame_valid,
    output logic [4*DIGITS-1:0]   frame_bcd,
    output logic                  frame_err,
    output logic                  overrun,
    output logic                  sel_err
);

    localparam logic [3:0] c_STABLE     = 4'(STABLE);
    localparam logic [3:0] c_CODE_BLANK = 4'hA;
    localparam logic [3:0] c_CODE_BAD   = 4'hF;

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic                  w_load;
    logic                  w_drop;
    logic [3:0]            w_code;
    logic                  w_sel_onehot;
    logic                  w_sample;
    logic                  w_commit;
    logic [DIGITS-1:0]     w_mask;
    logic [DIGITS-1:0]     w_bad;
    logic [4*DIGITS-1:0]   w_frame;
    logic [4*DIGITS-1:0]   r_frame_bcd;
    logic                  r_frame_err;
    logic                  r_overrun;
    logic                  r_sel_err;

    // Exact-match decode; anything unrecognised is flagged as code F.
    always_comb begin
        w_code = c_CODE_BAD;
        case (seg_in)
            7'h3F:   w_code = 4'd0;
            7'h06:   w_code = 4'd1;
            7'h5B:   w_code = 4'd2;
            7'h4F:   w_code = 4'd3;
            7'h66:   w_code = 4'd4;
            7'h6D:   w_code = 4'd5;
            7'h7D:   w_code = 4'd6;
            7'h07:   w_code = 4'd7;
            7'h7F:   w_code = 4'd8;
            7'h6F:   w_code = 4'd9;
            7'h00:   w_code = c_CODE_BLANK;
            default: w_code = c_CODE_BAD;
        endcase
    end

    assign w_sel_onehot = (dig_sel != '0) && ((dig_sel & (dig_sel - DIGITS'(1))) == '0);
    assign w_sample     = sample_en & w_sel_onehot;
    assign w_commit     = &w_mask;

    generate
        for (genvar i = 0; i < DIGITS; i++) begin : g_digit
            logic [3:0] r_cand;
            logic [3:0] r_cnt;
            logic [3:0] r_val;
            logic       r_acc;
            logic [3:0] w_cand_base;
            logic [3:0] w_cnt_base;
            logic [3:0] w_cnt_next;

            // A commit clears the filter first, so a coincident sample starts a new frame.
            always_comb begin
                w_cand_base = w_commit ? 4'd0 : r_cand;
                w_cnt_base  = w_commit ? 4'd0 : r_cnt;
                w_cnt_next  = 4'd1;
                if (w_code == w_cand_base) begin
                    w_cnt_next = (w_cnt_base == c_STABLE) ? c_STABLE : w_cnt_base + 4'd1;
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_cand <= 4'd0;
                    r_cnt  <= 4'd0;
                    r_val  <= 4'd0;
                    r_acc  <= 1'b0;
                end else if (w_sample && dig_sel[i]) begin
                    r_cand <= w_code;
                    r_cnt  <= w_cnt_next;
                    r_acc  <= (w_cnt_next == c_STABLE) | (r_acc & ~w_commit);
                    if (w_cnt_next == c_STABLE) begin
                        r_val <= w_code;
                    end
                end else if (w_commit) begin
                    r_cand <= 4'd0;
                    r_cnt  <= 4'd0;
                    r_acc  <= 1'b0;
                end
            end

            assign w_mask[i]         = r_acc;
            assign w_frame[i*4 +: 4] = r_val;
            assign w_bad[i]          = (r_val == c_CODE_BAD);
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_drop       = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                if (w_commit) begin
                    w_load       = 1'b1;
                    w_state_next = ST_FULL;
                end
            end
            ST_FULL: begin
                if (w_commit) begin
                    if (frame_ready) begin
                        w_load = 1'b1;
                    end else begin
                        w_drop = 1'b1;
                    end
                end else if (frame_ready) begin
                    w_state_next = ST_EMPTY;
                end
            end
            default: w_state_next = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_frame_bcd <= '0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
            r_sel_err   <= 1'b0;
        end else begin
            if (w_load) begin
                r_frame_bcd <= w_frame;
                r_frame_err <= |w_bad;
            end
            r_overrun <= w_drop;
            r_sel_err <= sample_en & ~w_sel_onehot;
        end
    end

    assign frame_valid = (r_state == ST_FULL);
    assign frame_bcd   = r_frame_bcd;
    assign frame_err   = r_frame_err;
    assign overrun     = r_overrun;
    assign sel_err     = r_sel_err;

endmodule
`default_nettype wire

// File: tb/tb_seg_frame_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg_frame_reader
// Purpose  : Directed plus randomized self-checking bench for seg_frame_reader.
// Revision : 1.0
// ============================================================================
module tb_seg_frame_reader;

    localparam int DIGITS = 4;
    localparam int STABLE = 3;

    logic                clk;
    logic                rst;
    logic [6:0]          seg_in;
    logic [DIGITS-1:0]   dig_sel;
    logic                sample_en;
    logic                frame_ready;
    logic                frame_valid;
    logic [4*DIGITS-1:0] frame_bcd;
    logic                frame_err;
    logic                overrun;
    logic                sel_err;

    seg_frame_reader #(.DIGITS(DIGITS), .STABLE(STABLE)) dut (
        .clk         (clk),
        .rst         (rst),
        .seg_in      (seg_in),
        .dig_sel     (dig_sel),
        .sample_en   (sample_en),
        .frame_ready (frame_ready),
        .frame_valid (frame_valid),
        .frame_bcd   (frame_bcd),
        .frame_err   (frame_err),
        .overrun     (overrun),
        .sel_err     (sel_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;
    int nframes = 0;

    logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    // Reference state: per-digit sample history since the frame began.
    logic [3:0]          hist [DIGITS][$];
    bit                  acc  [DIGITS];
    logic [3:0]          accv [DIGITS];
    bit                  pending;
    logic [4*DIGITS-1:0] pend_bcd;
    logic                pend_err;
    logic                exp_valid;
    logic [4*DIGITS-1:0] exp_bcd;
    logic                exp_err;
    logic                exp_ovr;
    logic                exp_sel;

    function automatic logic [3:0] ref_decode(input logic [6:0] s);
        for (int k = 0; k < 10; k++) begin
            if (seg_tab[k] == s) return 4'(k);
        end
        if (s == 7'h00) return 4'hA;
        return 4'hF;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < DIGITS; d++) begin
            hist[d].delete();
            acc[d]  = 1'b0;
            accv[d] = 4'd0;
        end
        pending   = 1'b0;
        pend_bcd  = '0;
        pend_err  = 1'b0;
        exp_valid = 1'b0;
        exp_bcd   = '0;
        exp_err   = 1'b0;
        exp_ovr   = 1'b0;
        exp_sel   = 1'b0;
    endtask

    task automatic model_edge(input logic en, input logic [DIGITS-1:0] sel,
                              input logic [6:0] seg, input logic rdy);
        int         d;
        int         run;
        bit         all_acc;
        logic [3:0] code;
        exp_ovr = 1'b0;
        exp_sel = en && ($countones(sel) != 1);
        if (pending) begin
            if (!exp_valid || rdy) begin
                exp_valid = 1'b1;
                exp_bcd   = pend_bcd;
                exp_err   = pend_err;
                nframes++;
            end else begin
                exp_ovr = 1'b1;
            end
            pending = 1'b0;
        end else if (exp_valid && rdy) begin
            exp_valid = 1'b0;
        end
        if (en && $countones(sel) == 1) begin
            d = 0;
            for (int k = 0; k < DIGITS; k++) if (sel[k]) d = k;
            code = ref_decode(seg);
            hist[d].push_back(code);
            run = 0;
            for (int k = hist[d].size() - 1; k >= 0; k--) begin
                if (hist[d][k] == code) run++;
                else break;
            end
            if (run == STABLE) begin
                acc[d]  = 1'b1;
                accv[d] = code;
            end
            all_acc = 1'b1;
            for (int k = 0; k < DIGITS; k++) all_acc &= acc[k];
            if (all_acc) begin
                pending  = 1'b1;
                pend_err = 1'b0;
                for (int k = 0; k < DIGITS; k++) begin
                    pend_bcd[k*4 +: 4] = accv[k];
                    if (accv[k] == 4'hF) pend_err = 1'b1;
                    hist[k].delete();
                    acc[k] = 1'b0;
                end
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input logic en, input logic [DIGITS-1:0] sel,
                        input logic [6:0] seg, input logic rdy);
        sample_en   = en;
        dig_sel     = sel;
        seg_in      = seg;
        frame_ready = rdy;
        @(posedge clk);
        model_edge(en, sel, seg, rdy);
        #1;
        chk("valid",   32'(frame_valid), 32'(exp_valid));
        chk("bcd",     32'(frame_bcd),   32'(exp_bcd));
        chk("err",     32'(frame_err),   32'(exp_err));
        chk("overrun", 32'(overrun),     32'(exp_ovr));
        chk("sel_err", 32'(sel_err),     32'(exp_sel));
    endtask

    task automatic idle(input logic rdy);
        step(1'b0, '0, 7'h00, rdy);
    endtask

    task automatic send_frame(input logic [6:0] p3, input logic [6:0] p2,
                              input logic [6:0] p1, input logic [6:0] p0,
                              input logic rdy);
        logic [6:0] p [DIGITS];
        p[3] = p3; p[2] = p2; p[1] = p1; p[0] = p0;
        for (int r = 0; r < STABLE; r++) begin
            for (int d = DIGITS - 1; d >= 0; d--) step(1'b1, 4'(1 << d), p[d], rdy);
        end
    endtask

    initial begin
        logic [6:0] ip [DIGITS];
        logic [6:0] p  [DIGITS];
        logic [3:0] bad_sel;
        rst = 1'b1; seg_in = '0; dig_sel = '0; sample_en = 1'b0; frame_ready = 1'b0;
        model_reset();
        #3;
        chk("rst_valid", 32'(frame_valid), 32'd0);
        chk("rst_bcd",   32'(frame_bcd),   32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Basic frame 0x1234 with the consumer always ready.
        send_frame(7'h06, 7'h5B, 7'h4F, 7'h66, 1'b1);
        chk("t1_valid_early", 32'(frame_valid), 32'd0);
        idle(1'b1);
        chk("t1_valid", 32'(frame_valid), 32'd1);
        chk("t1_bcd",   32'(frame_bcd),   32'h1234);
        chk("t1_err",   32'(frame_err),   32'd0);
        idle(1'b1);
        chk("t1_one_cycle", 32'(frame_valid), 32'd0);

        // Digit 0 glitches through 5 before settling on 6.
        for (int r = 0; r < 3; r++) begin
            for (int d = 3; d >= 1; d--) step(1'b1, 4'(1 << d), 7'h3F, 1'b1);
            step(1'b1, 4'b0001, (r < 2) ? 7'h6D : 7'h7D, 1'b1);
        end
        step(1'b1, 4'b0001, 7'h7D, 1'b1);
        step(1'b1, 4'b0001, 7'h7D, 1'b1);
        idle(1'b1);
        chk("t2_bcd", 32'(frame_bcd), 32'h0006);

        // Invalid and blank digits.
        for (int r = 0; r < 3; r++) begin
            step(1'b1, 4'b1000, 7'h07, 1'b1);
            step(1'b1, 4'b0100, 7'h49, 1'b1);
            step(1'b1, 4'b0001, 7'h7F, 1'b1);
        end
        for (int r = 0; r < 3; r++) step(1'b1, 4'b0010, 7'h00, 1'b1);
        idle(1'b1);
        chk("t3_bcd", 32'(frame_bcd), 32'h7FA8);
        chk("t3_err", 32'(frame_err), 32'd1);
        idle(1'b1);

        // Overrun while the consumer stalls.
        send_frame(7'h06, 7'h5B, 7'h4F, 7'h66, 1'b0);
        idle(1'b0);
        send_frame(7'h6D, 7'h7D, 7'h07, 7'h7F, 1'b0);
        idle(1'b0);
        chk("t4_overrun", 32'(overrun),   32'd1);
        chk("t4_bcd",     32'(frame_bcd), 32'h1234);
        idle(1'b0);
        chk("t4_ovr_pulse", 32'(overrun), 32'd0);
        idle(1'b1);
        chk("t4_released", 32'(frame_valid), 32'd0);
        send_frame(7'h6F, 7'h3F, 7'h06, 7'h5B, 1'b1);
        idle(1'b1);
        chk("t4_third", 32'(frame_bcd), 32'h9012);

        // Bad digit selects in the middle of a frame.
        p[3] = 7'h7F; p[2] = 7'h07; p[1] = 7'h66; p[0] = 7'h4F;
        for (int r = 0; r < 3; r++) begin
            for (int d = 3; d >= 0; d--) begin
                if (r == 1 && d == 2) begin
                    step(1'b1, 4'b0000, 7'h3F, 1'b1);
                    chk("t5_sel_zero", 32'(sel_err), 32'd1);
                    step(1'b1, 4'b0110, 7'h3F, 1'b1);
                    chk("t5_sel_multi", 32'(sel_err), 32'd1);
                end
                step(1'b1, 4'(1 << d), p[d], 1'b1);
            end
        end
        idle(1'b1);
        chk("t5_bcd", 32'(frame_bcd), 32'h8743);

        // Asynchronous reset with a held frame and three digits accepted.
        send_frame(7'h06, 7'h5B, 7'h4F, 7'h66, 1'b0);
        idle(1'b0);
        for (int r = 0; r < 3; r++) begin
            for (int d = 3; d >= 1; d--) step(1'b1, 4'(1 << d), 7'h6F, 1'b0);
        end
        chk("t6_held", 32'(frame_valid), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("t6_rst_valid", 32'(frame_valid), 32'd0);
        chk("t6_rst_bcd",   32'(frame_bcd),   32'd0);
        chk("t6_rst_err",   32'(frame_err),   32'd0);
        model_reset();
        #2 rst = 1'b0;
        for (int r = 0; r < 3; r++) begin
            for (int d = 3; d >= 0; d--) begin
                if (!(r == 2 && d == 0)) step(1'b1, 4'(1 << d), 7'h3F, 1'b1);
            end
        end
        idle(1'b1);
        chk("t6_partial", 32'(frame_valid), 32'd0);
        step(1'b1, 4'b0001, 7'h3F, 1'b1);
        idle(1'b1);
        chk("t6_valid", 32'(frame_valid), 32'd1);
        chk("t6_bcd",   32'(frame_bcd),   32'h0000);

        // Randomized traffic against the reference model.
        nframes = 0;
        for (int d = 0; d < DIGITS; d++) ip[d] = seg_tab[$urandom_range(9)];
        for (int n = 0; n < 3000; n++) begin
            int d;
            d = $urandom_range(DIGITS - 1);
            if ($urandom_range(5) == 0) begin
                case ($urandom_range(9))
                    8:       ip[d] = 7'h00;
                    9:       ip[d] = 7'($urandom);
                    default: ip[d] = seg_tab[$urandom_range(9)];
                endcase
            end
            if ($urandom_range(11) == 0) begin
                bad_sel = (4'($urandom_range(3)) == 4'd0) ? 4'b0000 : 4'b0011 << $urandom_range(2);
                step($urandom_range(9) < 8, bad_sel, ip[d], $urandom_range(9) < 7);
            end else begin
                step($urandom_range(9) < 8, 4'(1 << d), ip[d], $urandom_range(9) < 7);
            end
        end
        checks++;
        assert (nframes >= 5) else begin
            errors++;
            $error("FAIL rand_frames: observed %0d expected at least 5", nframes);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
